// File: rtl/seq_det_sched_pkg.sv
// Shared types and helpers for the sequence-detector time-share scheduler.
// No logic, so no latency or backpressure of its own.
package seq_det_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // FLUSH forces the detector reset; DONE reports the frame and re-arbitrates.
    localparam state_t DET_RST_STATE = FLUSH;
    localparam state_t REPORT_STATE  = DONE;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr wins; one-hot gnt plus index.
// Purely combinational, zero latency; no backpressure, en=0 forces an empty grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shares one serial sequence detector among N_CH channels, one FRAME_LEN-bit frame per grant.
// Frame period FRAME_LEN+DET_LAT+2 cycles; requesters wait (level ch_req) until the next arbitration point.
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = 16,
    parameter int DET_LAT   = 1,
    parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_req,
    input  logic [N_CH-1:0]  ch_bit,
    output logic [N_CH-1:0]  ch_gnt,
    output logic [N_CH-1:0]  ch_hit,
    output logic [N_CH-1:0]  ch_done,
    output logic [CNT_W-1:0] frame_hits,
    output logic             det_in,
    output logic             det_rst,
    input  logic             det_out
);

    localparam int IW = $clog2(N_CH);
    localparam int PW = $clog2(FRAME_LEN + DET_LAT + 1);
    localparam logic [PW-1:0] LAST_BIT = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] LAST_WIN = PW'(FRAME_LEN + DET_LAT - 1);

    state_t           state;
    logic [IW-1:0]    win;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_nxt;
    logic [IW-1:0]    arb_ptr;
    logic [IW-1:0]    arb_idx;
    logic [N_CH-1:0]  arb_gnt;
    logic [N_CH-1:0]  win_oh;
    logic [PW-1:0]    pos;
    logic [CNT_W-1:0] hit_cnt;
    logic             arb_en;
    logic             is_stream;
    logic             in_window;
    logic             hit_now;
    logic             frame_end;

    assign is_stream = (state == STREAM);
    assign arb_en    = (state == IDLE) || (state == REPORT_STATE);
    assign ptr_nxt   = (win == IW'(N_CH - 1)) ? '0 : win + 1'b1;
    // In DONE the just-served owner must drop to lowest priority, so search from w+1 now.
    assign arb_ptr   = (state == REPORT_STATE) ? ptr_nxt : ptr;
    assign win_oh    = N_CH'(1) << win;
    assign det_in    = |(ch_gnt & ch_bit);
    assign det_rst   = rst || (state == DET_RST_STATE);
    assign hit_now   = in_window && det_out;
    assign frame_end = ((state == STREAM) && (pos == LAST_BIT) && (DET_LAT == 0)) ||
                       ((state == DRAIN) && (pos == LAST_WIN));

    rr_arbiter #(.N(N_CH)) u_arb (
        .req (ch_req),
        .ptr (arb_ptr),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // The hit window is the STREAM interval shifted by the detector latency.
    generate
        if (DET_LAT == 0) begin : g_no_lat
            assign in_window = is_stream;
        end else begin : g_lat
            logic [DET_LAT-1:0] stream_dly;
            always_ff @(posedge clk) begin
                if (rst) begin
                    stream_dly <= '0;
                end else begin
                    stream_dly <= DET_LAT'({stream_dly, is_stream});
                end
            end
            assign in_window = stream_dly[DET_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            win        <= '0;
            ptr        <= '0;
            pos        <= '0;
            hit_cnt    <= '0;
            ch_gnt     <= '0;
            ch_hit     <= '0;
            ch_done    <= '0;
            frame_hits <= '0;
        end else begin
            ch_hit  <= hit_now ? win_oh : '0;
            ch_done <= '0;
            if (hit_now) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (frame_end) begin
                ch_done    <= win_oh;
                frame_hits <= hit_cnt + CNT_W'(hit_now);
            end
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        win   <= arb_idx;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    pos     <= '0;
                    hit_cnt <= '0;
                    ch_gnt  <= win_oh;
                    state   <= STREAM;
                end
                STREAM: begin
                    pos <= pos + 1'b1;
                    if (pos == LAST_BIT) begin
                        ch_gnt <= '0;
                        state  <= frame_end ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    pos <= pos + 1'b1;
                    if (frame_end) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    ptr <= ptr_nxt;
                    if (|arb_gnt) begin
                        win   <= arb_idx;
                        state <= FLUSH;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
